if_stage: RTL

//  Instruction-fetch stage. Holds the PC, drives the word address into the

---
 rtl/if_stage_if.sv | 35 +++
 rtl/if_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's handshake and bus signals.
// master: the fetch stage itself. slave: loader, memory and hazard/branch logic.
// Handshake: there is no valid/ready pairing here. im_en is a level: while it
// is high the loader owns the memory. start is a one-cycle pulse. stall, flush
// and redirect are sampled at each rising edge. if_valid qualifies the IF/ID
// outputs, and downstream consumes them whenever it is high.
interface if_stage_if;
    logic        im_en;
    logic        start;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        fetch_active;
    logic        pc_oob;
    logic [1:0]  state_dbg;

    modport master (
        input  im_en, start, im_data, stall, flush, redirect, redirect_pc,
        output im_addr, if_instr, if_pc, if_pc4, if_valid, fetch_active,
               pc_oob, state_dbg
    );

    modport slave (
        output im_en, start, im_data, stall, flush, redirect, redirect_pc,
        input  im_addr, if_instr, if_pc, if_pc4, if_valid, fetch_active,
               pc_oob, state_dbg
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, memory address drive and the IF/ID
// pipeline register. It is frozen while the loader owns memory. It honours
// stall, flush and redirect from downstream, and halts for good once the PC
// leaves the memory range.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int          AW       = 7
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // The PC is always kept word-aligned, so im_addr[1:0] is always 00.
    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic        oob_q, oob_d;
    logic        pc_out_of_range;

    // A PC with any bit set above the word index addresses past the memory.
    assign pc_out_of_range = |pc_q[31:AW+2];

    // Next-state, PC and IF/ID update. Everything holds by default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        oob_d   = oob_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.im_en) begin
                    state_d = S_LOAD;
                    pc_d    = PC_INIT;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                pc_d    = PC_INIT;
                instr_d = NOP;
                valid_d = 1'b0;
                if (!bus.im_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.im_en) begin
                    state_d = S_LOAD;
                    pc_d    = PC_INIT;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else if (pc_out_of_range) begin
                    // The offending word is dropped and the PC stays frozen.
                    state_d = S_HALT;
                    oob_d   = 1'b1;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else if (bus.redirect) begin
                    // The in-flight word is on the wrong path, so it is squashed.
                    pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    if (bus.flush) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end else begin
                    pc_d = pc_q + 32'd4;
                    if (bus.flush) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.im_data;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_q + 32'd4;
                        valid_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            instr_q <= NOP;
            ifpc_q  <= 32'd0;
            ifpc4_q <= 32'd0;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            oob_q   <= oob_d;
        end
    end

    assign bus.im_addr      = pc_q;
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = ifpc_q;
    assign bus.if_pc4       = ifpc4_q;
    assign bus.if_valid     = valid_q;
    assign bus.fetch_active = (state_q == S_RUN);
    assign bus.pc_oob       = oob_q;
    assign bus.state_dbg    = state_q;

endmodule
